// File: rtl/ysyx_24110006_axi_rom_rd_pkg.sv
// ysyx_24110006_axi_rom_rd_pkg: AXI read encodings, response codes and responder FSM states.
package ysyx_24110006_axi_rom_rd_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_WORD   = 3'b010;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
    endfunction
endpackage

// File: rtl/ysyx_24110006_axi_burst_addr.sv
// ysyx_24110006_axi_burst_addr: next beat address for FIXED/INCR/WRAP bursts.
//   addr      current beat byte address
//   len       beats minus one
//   burst     AXI burst type
//   next_addr address of the following beat
module ysyx_24110006_axi_burst_addr
    import ysyx_24110006_axi_rom_rd_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [7:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);
    logic [31:0] inc;
    logic [31:0] mask;

    always_comb begin
        inc       = addr + 32'd4;
        mask      = (({24'd0, len} + 32'd1) << 2) - 32'd1;
        next_addr = burst == BURST_FIXED ? addr :
                    burst == BURST_WRAP  ? (addr & ~mask) | (inc & mask) : inc;
    end
endmodule

// File: rtl/ysyx_24110006_axi_rom_rd.sv
// ysyx_24110006_axi_rom_rd: single-outstanding AXI4 read responder over a preloadable word array.
//   i_clock/i_reset_n   clock, async active-low reset
//   i_axi_ar*/o_axi_arready  read address channel
//   o_axi_r*/i_axi_rready    read data channel
//   i_ld_en/i_ld_addr/i_ld_data  side-band word preload port
module ysyx_24110006_axi_rom_rd
    import ysyx_24110006_axi_rom_rd_pkg::*;
#(
    parameter int          DEPTH = 4096,
    parameter logic [31:0] BASE  = 32'h8000_0000,
    parameter int          LAT   = 1
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [31:0] i_axi_araddr,
    input  logic        i_axi_arvalid,
    output logic        o_axi_arready,
    input  logic [3:0]  i_axi_arid,
    input  logic [7:0]  i_axi_arlen,
    input  logic [2:0]  i_axi_arsize,
    input  logic [1:0]  i_axi_arburst,
    output logic [31:0] o_axi_rdata,
    output logic        o_axi_rvalid,
    input  logic        i_axi_rready,
    output logic [1:0]  o_axi_rresp,
    output logic [3:0]  o_axi_rid,
    output logic        o_axi_rlast,
    input  logic        i_ld_en,
    input  logic [31:0] i_ld_addr,
    input  logic [31:0] i_ld_data
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] SPAN      = 32'(4 * DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(LAT > 0 ? LAT - 1 : 0);

    logic [31:0] mem [DEPTH];
    state_t      state, nstate;
    logic [31:0] addr, next_addr, fill_addr, fill_off, ld_off;
    logic [3:0]  len, cnt, wcnt, ar_len, fill_cnt;
    logic [1:0]  burst;
    logic        err, ar_err, ar_hs, fill, fill_err, fill_last, fill_bad;

    assign o_axi_arready = state == S_IDLE;
    assign o_axi_rvalid  = state == S_DATA;
    assign ar_hs  = o_axi_arready && i_axi_arvalid;
    // lengths above 15 are errors but still counted as 16 beats
    assign ar_len = i_axi_arlen > 8'd15 ? 4'd15 : i_axi_arlen[3:0];
    assign ar_err = i_axi_arsize != SIZE_WORD || i_axi_arburst == 2'b11 || i_axi_arlen > 8'd15 ||
                    i_axi_araddr[1:0] != 2'b00 || (i_axi_arburst == BURST_WRAP && !wrap_len_ok(i_axi_arlen));
    assign ld_off = i_ld_addr - BASE;

    ysyx_24110006_axi_burst_addr u_next (
        .addr      (addr),
        .len       ({4'd0, len}),
        .burst     (burst),
        .next_addr (next_addr)
    );

    // fill marks an edge that loads a beat into the R payload registers
    always_comb begin
        nstate    = state;
        fill      = 1'b0;
        fill_addr = addr;
        fill_err  = err;
        fill_cnt  = cnt + 4'd1;
        case (state)
            S_IDLE: begin
                fill      = ar_hs && LAT == 0;
                fill_addr = i_axi_araddr;
                fill_err  = ar_err;
                fill_cnt  = 4'd0;
                nstate    = ar_hs ? (LAT == 0 ? S_DATA : S_WAIT) : S_IDLE;
            end
            S_WAIT: begin
                fill     = wcnt == 4'd0;
                fill_cnt = 4'd0;
                nstate   = wcnt == 4'd0 ? S_DATA : S_WAIT;
            end
            S_DATA: begin
                fill      = i_axi_rready && cnt != len;
                fill_addr = next_addr;
                nstate    = i_axi_rready && cnt == len ? S_IDLE : S_DATA;
            end
            default: nstate = S_IDLE;
        endcase
        fill_last = fill_cnt == (state == S_IDLE ? ar_len : len);
        fill_off  = fill_addr - BASE;
        fill_bad  = fill_err || fill_off >= SPAN;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= S_IDLE;
            addr        <= '0;
            len         <= '0;
            burst       <= BURST_FIXED;
            err         <= 1'b0;
            cnt         <= '0;
            wcnt        <= '0;
            o_axi_rdata <= '0;
            o_axi_rresp <= RESP_OKAY;
            o_axi_rid   <= '0;
            o_axi_rlast <= 1'b0;
        end else begin
            state <= nstate;
            if (ar_hs) begin
                addr      <= i_axi_araddr;
                len       <= ar_len;
                burst     <= i_axi_arburst;
                err       <= ar_err;
                o_axi_rid <= i_axi_arid;
                cnt       <= '0;
                wcnt      <= WAIT_INIT;
            end else if (state == S_WAIT && wcnt != 4'd0) begin
                wcnt <= wcnt - 4'd1;
            end
            if (fill) begin
                addr        <= fill_addr;
                cnt         <= fill_cnt;
                o_axi_rdata <= fill_bad ? 32'd0 : mem[fill_off[AW+1:2]];
                o_axi_rresp <= fill_bad ? RESP_SLVERR : RESP_OKAY;
                o_axi_rlast <= fill_last;
            end
        end
    end

    // array is not reset so preloaded contents survive a mid-burst reset
    always_ff @(posedge i_clock) begin
        if (i_ld_en && ld_off < SPAN) mem[ld_off[AW+1:2]] <= i_ld_data;
    end
endmodule

// File: tb/tb_ysyx_24110006_axi_rom_rd.sv
// tb_ysyx_24110006_axi_rom_rd: directed and random read bursts checked against a word-array model.
module tb_ysyx_24110006_axi_rom_rd;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          LAT   = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    always #5 clk = ~clk;

    ysyx_24110006_axi_rom_rd #(.DEPTH(DEPTH), .BASE(BASE), .LAT(LAT)) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_axi_araddr  (araddr),
        .i_axi_arvalid (arvalid),
        .o_axi_arready (arready),
        .i_axi_arid    (arid),
        .i_axi_arlen   (arlen),
        .i_axi_arsize  (arsize),
        .i_axi_arburst (arburst),
        .o_axi_rdata   (rdata),
        .o_axi_rvalid  (rvalid),
        .i_axi_rready  (rready),
        .o_axi_rresp   (rresp),
        .o_axi_rid     (rid),
        .o_axi_rlast   (rlast),
        .i_ld_en       (ld_en),
        .i_ld_addr     (ld_addr),
        .i_ld_data     (ld_data)
    );

    logic [31:0] mdl [DEPTH];
    logic [31:0] exp_data [$];
    logic [1:0]  exp_resp [$];
    int          errors = 0;
    int          checks = 0;
    bit          chain = 1'b0;
    bit          collide = 1'b0;
    logic [31:0] c_addr, cdata;
    logic [3:0]  c_id;
    logic [7:0]  c_len;
    logic [1:0]  c_burst;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_range(input longint a);
        return a >= longint'(BASE) && a < longint'(BASE) + 4 * DEPTH;
    endfunction

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en = 1'b0;
        if (in_range(longint'(a))) mdl[(a - BASE) >> 2] = d;
    endtask

    // expected beats from the burst rules: beat i sits at start, start+4i, or wraps inside an aligned block
    function automatic void build(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int     n = (len > 8'd15 ? 15 : int'(len)) + 1;
        bit     wrap_ok = len == 1 || len == 3 || len == 7 || len == 15;
        bit     err = size != 3'b010 || burst == 2'b11 || len > 8'd15 || a[1:0] != 2'b00 || (burst == 2'b10 && !wrap_ok);
        longint bytes = 4 * n;
        longint lo = (longint'(a) / bytes) * bytes;
        exp_data.delete();
        exp_resp.delete();
        for (int i = 0; i < n; i++) begin
            longint ba = burst == 2'b00 ? longint'(a) :
                         burst == 2'b10 ? lo + (longint'(a) - lo + 4 * i) % bytes :
                         (longint'(a) + 4 * i) % 64'h1_0000_0000;
            bit ok = !err && in_range(ba);
            exp_data.push_back(ok ? mdl[(ba - longint'(BASE)) / 4] : 32'd0);
            exp_resp.push_back(ok ? 2'b00 : 2'b10);
        end
    endfunction

    task automatic rd(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [2:0] size,
                      input logic [1:0] burst, input int mode, input int abort_at);
        int n;
        bit tog = 1'b1;
        build(a, len, size, burst);
        araddr = a;
        arid = id;
        arlen = len;
        arsize = size;
        arburst = burst;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 200) begin
            tick();
            n++;
        end
        check("ar_accept_timeout", 32'(n < 200), 32'd1);
        tick();
        if (chain) begin
            araddr = c_addr;
            arid = c_id;
            arlen = c_len;
            arburst = c_burst;
            chain = 1'b0;
        end else begin
            arvalid = 1'b0;
        end
        n = 1;
        while (!rvalid && n < 200) begin
            check("arready_while_wait", 32'(arready), 32'd0);
            if (collide && n == LAT) begin
                ld_en = 1'b1;
                ld_addr = a;
                ld_data = cdata;
            end
            tick();
            ld_en = 1'b0;
            n++;
        end
        if (collide) begin
            mdl[(a - BASE) >> 2] = cdata;
            collide = 1'b0;
        end
        check("first_beat_latency", 32'(n), 32'(LAT + 1));
        for (int b = 0; b < exp_data.size(); b++) begin
            int stalls = 0;
            while (1) begin
                rready = (mode == 0 || stalls > 20) ? 1'b1 : mode == 1 ? tog : 1'($urandom_range(0, 1));
                check("rvalid", 32'(rvalid), 32'd1);
                check("rdata", rdata, exp_data[b]);
                check("rresp", 32'(rresp), 32'(exp_resp[b]));
                check("rid", 32'(rid), 32'(id));
                check("rlast", 32'(rlast), 32'(b == exp_data.size() - 1));
                check("arready_busy", 32'(arready), 32'd0);
                if (b == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    check("reset_rvalid_async", 32'(rvalid), 32'd0);
                    check("reset_arready_async", 32'(arready), 32'd1);
                    arvalid = 1'b0;
                    rready = 1'b0;
                    tick();
                    rst_n = 1'b1;
                    tick();
                    check("arready_after_release", 32'(arready), 32'd1);
                    return;
                end
                tick();
                tog = !tog;
                if (rready) break;
                stalls++;
            end
        end
        rready = 1'b0;
        check("rvalid_after_burst", 32'(rvalid), 32'd0);
        check("arready_after_burst", 32'(arready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        araddr = '0;
        arvalid = 1'b0;
        arid = '0;
        arlen = '0;
        arsize = 3'b010;
        arburst = 2'b01;
        rready = 1'b0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        tick();
        tick();
        check("reset_arready", 32'(arready), 32'd1);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_rresp", 32'(rresp), 32'd0);
        check("reset_rid", 32'(rid), 32'd0);
        check("reset_rlast", 32'(rlast), 32'd0);
        rst_n = 1'b1;
        tick();

        load(BASE, 32'h0000_0413);
        for (int i = 1; i < 256; i++) load(BASE + 32'(4 * i), $urandom);
        load(BASE + 32'(4 * DEPTH), 32'hDEAD_BEEF);
        load(BASE - 32'd4, 32'hBAD0_BAD0);

        rd(BASE, 4'd3, 8'd0, 3'b010, 2'b00, 0, -1);
        rd(BASE + 32'h8, 4'd5, 8'd3, 3'b010, 2'b01, 1, -1);
        rd(BASE + 32'h18, 4'd7, 8'd3, 3'b010, 2'b10, 0, -1);
        rd(32'h7FFF_FFF0, 4'd1, 8'd1, 3'b010, 2'b01, 0, -1);
        rd(BASE + 32'h20, 4'd2, 8'd0, 3'b001, 2'b01, 0, -1);
        rd(BASE + 32'h20, 4'd4, 8'd1, 3'b010, 2'b11, 0, -1);
        rd(BASE + 32'h22, 4'd6, 8'd0, 3'b010, 2'b01, 0, -1);
        rd(BASE + 32'h30, 4'd8, 8'd2, 3'b010, 2'b10, 0, -1);
        rd(BASE + 32'h40, 4'd9, 8'd20, 3'b010, 2'b01, 0, -1);
        rd(BASE + 32'h3FF0 + 32'h8, 4'd10, 8'd3, 3'b010, 2'b01, 0, -1);
        rd(BASE + 32'h2C, 4'd11, 8'd3, 3'b010, 2'b00, 2, -1);

        c_addr = BASE + 32'h40;
        c_id = 4'd12;
        c_len = 8'd1;
        c_burst = 2'b01;
        chain = 1'b1;
        rd(BASE + 32'h80, 4'd4, 8'd3, 3'b010, 2'b01, 0, -1);
        rd(BASE + 32'h40, 4'd12, 8'd1, 3'b010, 2'b01, 0, -1);

        cdata = 32'hC011_1DE5;
        collide = 1'b1;
        rd(BASE + 32'h60, 4'd13, 8'd0, 3'b010, 2'b01, 0, -1);
        rd(BASE + 32'h60, 4'd13, 8'd0, 3'b010, 2'b01, 0, -1);

        rd(BASE + 32'h100, 4'd6, 8'd7, 3'b010, 2'b01, 0, 1);
        rd(BASE, 4'd1, 8'd0, 3'b010, 2'b01, 0, -1);
        rd(BASE + 32'h100, 4'd2, 8'd7, 3'b010, 2'b01, 0, -1);

        for (int t = 0; t < 30; t++) begin
            logic [1:0]  bt = 2'($urandom_range(0, 2));
            logic [7:0]  ln = bt == 2'b10 ? 8'((4 << $urandom_range(0, 2)) - 1) : 8'($urandom_range(0, 15));
            logic [31:0] ad = BASE + 32'(4 * $urandom_range(0, 200));
            if ($urandom_range(0, 3) == 0) load(BASE + 32'(4 * $urandom_range(0, 255)), $urandom);
            if (bt == 2'b10 && $urandom_range(0, 1) == 1) ln = 8'd1;
            rd(ad, 4'($urandom), ln, 3'b010, bt, $urandom_range(0, 2), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
